// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator with valid/ready handshake and a one-entry skid buffer.
// Decodes the immediate format from the raw opcode/funct3 and stores decoded beats in output/skid registers.
module imm_gen_stage #(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_fmt
);
  typedef enum logic [3:0] {
    FMT_NONE   = 4'd0,
    FMT_I      = 4'd1,
    FMT_S      = 4'd2,
    FMT_B      = 4'd3,
    FMT_U      = 4'd4,
    FMT_J      = 4'd5,
    FMT_SHAMT  = 4'd6,
    FMT_SHAMTW = 4'd7,
    FMT_CSRI   = 4'd8
  } fmt_e;
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
  } beat_t;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       sh;
  fmt_e       fmt_dec;
  logic [XLEN-1:0] imm_dec;
  beat_t in_beat;
  beat_t out_q, out_d, skid_q, skid_d;
  logic  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic  accept, out_load;
  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign sh  = f3[1:0] == 2'b01;
  // OP-IMM-32 only exists on RV64; on RV32 it falls through to NONE.
  always_comb begin
    fmt_dec = (opc == 7'b0000011 || opc == 7'b1100111) ? FMT_I :
              (opc == 7'b0010011) ? (sh ? FMT_SHAMT : FMT_I) :
              (opc == 7'b0011011 && XLEN == 64) ? (sh ? FMT_SHAMTW : FMT_I) :
              (opc == 7'b0100011) ? FMT_S :
              (opc == 7'b1100011) ? FMT_B :
              (opc == 7'b0110111 || opc == 7'b0010111) ? FMT_U :
              (opc == 7'b1101111) ? FMT_J :
              (opc == 7'b1110011 && f3[2]) ? FMT_CSRI : FMT_NONE;
  end
  always_comb begin
    imm_dec = '0;
    case (fmt_dec)
      FMT_I:      imm_dec = XLEN'($signed(in_instr[31:20]));
      FMT_S:      imm_dec = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      FMT_B:      imm_dec = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
      FMT_U:      imm_dec = XLEN'($signed({in_instr[31:12], 12'b0}));
      FMT_J:      imm_dec = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
      FMT_SHAMT:  imm_dec = XLEN'(in_instr[20+SHAMT_W-1:20]);
      FMT_SHAMTW: imm_dec = XLEN'(in_instr[24:20]);
      FMT_CSRI:   imm_dec = XLEN'(in_instr[19:15]);
      default:    imm_dec = '0;
    endcase
  end
  assign in_beat  = '{instr: in_instr, pc: in_pc, imm: imm_dec, fmt: fmt_dec};
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign out_load = !out_valid_q || out_ready;
  // Skid drains ahead of new input to keep FIFO order; in_ready is 0 whenever skid is full.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_load) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        out_d       = accept ? in_beat : out_q;
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_instr = out_q.instr;
  assign out_pc    = out_q.pc;
  assign out_imm   = out_q.imm;
  assign out_fmt   = out_q.fmt;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed bench running RV64 and RV32 instances side by side on shared stimulus.
module tb_imm_gen_stage;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        r64, v64, r32, v32;
  logic [31:0] i64, i32;
  logic [63:0] p64, m64;
  logic [31:0] p32, m32;
  logic [3:0]  f64, f32;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  imm_gen_stage #(.XLEN(64)) d64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
    .out_instr(i64), .out_pc(p64), .out_imm(m64), .out_fmt(f64)
  );
  imm_gen_stage #(.XLEN(32)) d32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
    .out_instr(i32), .out_pc(p32), .out_imm(m32), .out_fmt(f32)
  );
  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'hFFF00093; in_pc = 64'hDEAD;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    vecs++;
    if (v64 !== 1'b0 || r64 !== 1'b1 || m64 !== 64'd0 || f64 !== 4'd0 || i64 !== 32'd0 || p64 !== 64'd0) begin
      errs++;
      $display("FAIL reset: valid=%b ready=%b imm=%h fmt=%0d instr=%h pc=%h, want 0 1 0 0 0 0", v64, r64, m64, f64, i64, p64);
    end
    vecs++;
    if (v32 !== 1'b0 || r32 !== 1'b1 || m32 !== 32'd0 || f32 !== 4'd0) begin
      errs++;
      $display("FAIL reset32: valid=%b ready=%b imm=%h fmt=%0d, want 0 1 0 0", v32, r32, m32, f32);
    end
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_decode();
    logic [31:0] ins [14];
    logic [63:0] e64 [14];
    logic [3:0]  ef64 [14];
    logic [31:0] e32 [14];
    logic [3:0]  ef32 [14];
    ins  = '{32'hFFF00093, 32'h123450B7, 32'hFFDFF06F, 32'h000FD073, 32'h03F09093, 32'h0010809B, 32'h0050909B,
             32'hFE512C23, 32'hFE000EE3, 32'h800000B7, 32'h00000073, 32'h0000007F, 32'hFFF0B083, 32'h4020D093};
    e64  = '{64'hFFFFFFFFFFFFFFFF, 64'h12345000, 64'hFFFFFFFFFFFFFFFC, 64'd31, 64'd63, 64'd1, 64'd5,
             64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'd2};
    ef64 = '{4'd1, 4'd4, 4'd5, 4'd8, 4'd6, 4'd1, 4'd7, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd1, 4'd6};
    e32  = '{32'hFFFFFFFF, 32'h12345000, 32'hFFFFFFFC, 32'd31, 32'd31, 32'd0, 32'd0,
             32'hFFFFFFF8, 32'hFFFFFFFC, 32'h80000000, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd2};
    ef32 = '{4'd1, 4'd4, 4'd5, 4'd8, 4'd6, 4'd0, 4'd0, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd1, 4'd6};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_instr = ins[i]; in_pc = 64'h8000_0000_0000_1000 + 64'(i * 4);
      @(negedge clk);
      in_valid = 1'b0;
      vecs++;
      if (v64 !== 1'b1 || m64 !== e64[i] || f64 !== ef64[i] || i64 !== ins[i] || p64 !== 64'h8000_0000_0000_1000 + 64'(i * 4)) begin
        errs++;
        $display("FAIL decode64[%0d] %h: valid=%b imm=%h fmt=%0d instr=%h pc=%h, want imm=%h fmt=%0d", i, ins[i], v64, m64, f64, i64, p64, e64[i], ef64[i]);
      end
      vecs++;
      if (v32 !== 1'b1 || m32 !== e32[i] || f32 !== ef32[i] || p32 !== 32'h1000 + 32'(i * 4)) begin
        errs++;
        $display("FAIL decode32[%0d] %h: valid=%b imm=%h fmt=%0d pc=%h, want imm=%h fmt=%0d", i, ins[i], v32, m32, f32, p32, e32[i], ef32[i]);
      end
    end
    in_instr = 32'h00500093;
    @(negedge clk);
    vecs++;
    if (v64 !== 1'b0 || m64 !== 64'd2 || f64 !== 4'd6 || p64 !== 64'h8000_0000_0000_1034) begin
      errs++;
      $display("FAIL idle_hold: valid=%b imm=%h fmt=%0d pc=%h, want 0 2 6 8000000000001034", v64, m64, f64, p64);
    end
  endtask
  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'hA0;
    @(negedge clk);
    vecs++;
    if (r64 !== 1'b1 || v64 !== 1'b1 || m64 !== 64'd1) begin
      errs++;
      $display("FAIL bp_a: ready=%b valid=%b imm=%h, want 1 1 1", r64, v64, m64);
    end
    in_instr = 32'h00200093; in_pc = 64'hB0;
    @(negedge clk);
    in_instr = 32'h00300093; in_pc = 64'hC0;
    vecs++;
    if (r64 !== 1'b0 || v64 !== 1'b1 || m64 !== 64'd1 || p64 !== 64'hA0) begin
      errs++;
      $display("FAIL bp_full: ready=%b valid=%b imm=%h pc=%h, want 0 1 1 a0", r64, v64, m64, p64);
    end
    @(negedge clk);
    vecs++;
    if (r64 !== 1'b0 || v64 !== 1'b1 || m64 !== 64'd1 || i64 !== 32'h00100093) begin
      errs++;
      $display("FAIL bp_hold: ready=%b valid=%b imm=%h instr=%h, want 0 1 1 00100093", r64, v64, m64, i64);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vecs++;
    if (r64 !== 1'b1 || v64 !== 1'b1 || m64 !== 64'd2 || p64 !== 64'hB0) begin
      errs++;
      $display("FAIL bp_b: ready=%b valid=%b imm=%h pc=%h, want 1 1 2 b0", r64, v64, m64, p64);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vecs++;
    if (v64 !== 1'b1 || m64 !== 64'd3 || p64 !== 64'hC0) begin
      errs++;
      $display("FAIL bp_c: valid=%b imm=%h pc=%h, want 1 3 c0", v64, m64, p64);
    end
    @(negedge clk);
    vecs++;
    if (v64 !== 1'b0 || r64 !== 1'b1 || m64 !== 64'd3) begin
      errs++;
      $display("FAIL bp_drain: valid=%b ready=%b imm=%h, want 0 1 3", v64, r64, m64);
    end
  endtask
  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00700093; in_pc = 64'h100;
    @(negedge clk);
    in_instr = 32'h00800093; in_pc = 64'h104;
    @(negedge clk);
    in_instr = 32'h00900093; in_pc = 64'h108; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vecs++;
    if (v64 !== 1'b0 || r64 !== 1'b1) begin
      errs++;
      $display("FAIL flush: valid=%b ready=%b, want 0 1", v64, r64);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vecs++;
      if (v64 !== 1'b0 || m64 !== 64'd7 || p64 !== 64'h100) begin
        errs++;
        $display("FAIL flush_quiet[%0d]: valid=%b imm=%h pc=%h, want 0 7 100", k, v64, m64, p64);
      end
    end
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00A00093; in_pc = 64'h200;
    @(negedge clk);
    in_instr = 32'h00B00093; in_pc = 64'h204;
    @(negedge clk);
    in_instr = 32'h00C00093; in_pc = 64'h208; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vecs++;
    if (v64 !== 1'b0 || r64 !== 1'b1 || m64 !== 64'd0 || f64 !== 4'd0 || i64 !== 32'd0 || p64 !== 64'd0) begin
      errs++;
      $display("FAIL reset_mid: valid=%b ready=%b imm=%h fmt=%0d instr=%h pc=%h, want 0 1 0 0 0 0", v64, r64, m64, f64, i64, p64);
    end
    in_valid = 1'b1; in_instr = 32'h00D00093; in_pc = 64'h300;
    @(negedge clk);
    in_valid = 1'b0;
    vecs++;
    if (v64 !== 1'b1 || m64 !== 64'd13 || f64 !== 4'd1 || p64 !== 64'h300) begin
      errs++;
      $display("FAIL reset_first: valid=%b imm=%h fmt=%0d pc=%h, want 1 d 1 300", v64, m64, f64, p64);
    end
    @(negedge clk);
    vecs++;
    if (v64 !== 1'b0) begin
      errs++;
      $display("FAIL reset_stale: valid=%b, want 0", v64);
    end
  endtask
  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
